rs_oldest_first: RTL and testbench

- Parametrised reservation station for the out-of-order RV32I core. Sits between issue/decode and the ALU/branch FU; the ROB provides the source and destination tags.
- Holds waiting ALU operations and snoops CDB_N result broadcast channels (ALU, LSB, extra FUs).
- Dispatches the oldest ready entry to the FU over a valid/ready handshake with backpressure.
- Flushed on branch mispredict.

---
 rtl/rs_oldest_first_if.sv | 40 ++++
 rtl/rs_oldest_first.sv | 175 +++++++++++++++++
 tb/tb_rs_oldest_first.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rs_oldest_first_if.sv
// Issue / CDB / FU bundle for the oldest-first reservation station.
interface rs_oldest_first_if #(
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6,
  parameter int CDB_N   = 2
);
  logic                     issue_valid;
  logic [OP_LOG-1:0]        issue_op;
  logic [31:0]              issue_Vj, issue_Vk;
  logic                     issue_Rj, issue_Rk;
  logic [ROB_LOG-1:0]       issue_Qj, issue_Qk;
  logic [31:0]              issue_Imm;
  logic [ROB_LOG-1:0]       issue_DestRob;
  logic [31:0]              issue_CurPC;

  logic [CDB_N-1:0]         cdb_valid;
  logic [CDB_N*ROB_LOG-1:0] cdb_RobId;
  logic [CDB_N*32-1:0]      cdb_value;

  logic                     FU_valid;
  logic                     FU_ready;
  logic [OP_LOG-1:0]        FU_op;
  logic [31:0]              FU_Vj, FU_Vk, FU_Imm;
  logic [ROB_LOG-1:0]       FU_DestRob;
  logic [31:0]              FU_CurPC;

  modport master (
    output issue_valid, issue_op, issue_Vj, issue_Vk, issue_Rj, issue_Rk,
           issue_Qj, issue_Qk, issue_Imm, issue_DestRob, issue_CurPC,
           cdb_valid, cdb_RobId, cdb_value, FU_ready,
    input  FU_valid, FU_op, FU_Vj, FU_Vk, FU_Imm, FU_DestRob, FU_CurPC
  );

  modport slave (
    input  issue_valid, issue_op, issue_Vj, issue_Vk, issue_Rj, issue_Rk,
           issue_Qj, issue_Qk, issue_Imm, issue_DestRob, issue_CurPC,
           cdb_valid, cdb_RobId, cdb_value, FU_ready,
    output FU_valid, FU_op, FU_Vj, FU_Vk, FU_Imm, FU_DestRob, FU_CurPC
  );
endinterface

// File: rtl/rs_oldest_first.sv
// Reservation station: holds ALU ops, snoops the CDB, dispatches the oldest
// ready entry to the FU through a registered valid/ready bundle.
module rs_oldest_first #(
  parameter int RS_SIZE = 16,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6,
  parameter int CDB_N   = 2,
  localparam int IDX_W  = $clog2(RS_SIZE),
  localparam int CNT_W  = $clog2(RS_SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_flag,
  output logic              RS_next_full,
  output logic [CNT_W-1:0]  RS_count,
  rs_oldest_first_if.slave  bus
);

  typedef struct packed {
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic               rj;
    logic               rk;
    logic [ROB_LOG-1:0] qj;
    logic [ROB_LOG-1:0] qk;
    logic [31:0]        imm;
    logic [ROB_LOG-1:0] dest;
    logic [31:0]        pc;
  } ent_t;

  ent_t               r_ent  [RS_SIZE];
  logic [IDX_W-1:0]   r_rank [RS_SIZE];
  logic [RS_SIZE-1:0] r_busy;

  logic               r_fu_valid;
  ent_t               r_fu;

  logic [CNT_W-1:0]   w_count;
  logic               w_sel_found, w_free_found, w_fire, w_iss;
  logic [IDX_W-1:0]   w_sel_idx, w_sel_rank, w_free_idx, w_new_rank;
  logic [32:0]        w_wj [RS_SIZE];
  logic [32:0]        w_wk [RS_SIZE];
  logic [32:0]        w_bj, w_bk;
  ent_t               w_new;

  // {hit, value} of the lowest CDB channel broadcasting tag q
  function automatic logic [32:0] snoop(
    input logic [ROB_LOG-1:0]       q,
    input logic [CDB_N-1:0]         v,
    input logic [CDB_N*ROB_LOG-1:0] ids,
    input logic [CDB_N*32-1:0]      vals
  );
    logic [32:0] res;
    res = '0;
    for (int c = CDB_N-1; c >= 0; c--)
      if (v[c] && ids[c*ROB_LOG +: ROB_LOG] == q) res = {1'b1, vals[c*32 +: 32]};
    return res;
  endfunction

  // occupancy and lowest free slot
  always_comb begin
    w_count      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      w_count = w_count + CNT_W'(r_busy[i]);
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // oldest ready entry, registered state only
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_rank  = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (r_busy[i] && r_ent[i].rj && r_ent[i].rk &&
          (!w_sel_found || r_rank[i] < w_sel_rank)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_rank  = r_rank[i];
      end
  end

  // per-entry CDB wakeup
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wj[i] = snoop(r_ent[i].qj, bus.cdb_valid, bus.cdb_RobId, bus.cdb_value);
      w_wk[i] = snoop(r_ent[i].qk, bus.cdb_valid, bus.cdb_RobId, bus.cdb_value);
    end
  end

  assign w_bj = snoop(bus.issue_Qj, bus.cdb_valid, bus.cdb_RobId, bus.cdb_value);
  assign w_bk = snoop(bus.issue_Qk, bus.cdb_valid, bus.cdb_RobId, bus.cdb_value);

  // incoming entry with same-cycle CDB bypass on its operands
  always_comb begin
    w_new      = '{op: bus.issue_op, vj: bus.issue_Vj, vk: bus.issue_Vk,
                   rj: bus.issue_Rj, rk: bus.issue_Rk, qj: bus.issue_Qj,
                   qk: bus.issue_Qk, imm: bus.issue_Imm, dest: bus.issue_DestRob,
                   pc: bus.issue_CurPC};
    if (!bus.issue_Rj && w_bj[32]) begin
      w_new.vj = w_bj[31:0];
      w_new.rj = 1'b1;
    end
    if (!bus.issue_Rk && w_bk[32]) begin
      w_new.vk = w_bk[31:0];
      w_new.rk = 1'b1;
    end
  end

  assign w_fire     = w_sel_found && (!r_fu_valid || bus.FU_ready);
  // issue into a full station is dropped; a slot freed this cycle is not reused
  assign w_iss      = bus.issue_valid && w_free_found;
  assign w_new_rank = IDX_W'(w_count - CNT_W'(w_fire));

  // entry state, ages and the FU bundle register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_fu_valid <= 1'b0;
      r_fu       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_rank[i] <= '0;
        r_ent[i]  <= '0;
      end
    end else if (jump_flag) begin
      r_busy     <= '0;
      r_fu_valid <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) r_rank[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++)
        if (r_busy[i]) begin
          if (!r_ent[i].rj && w_wj[i][32]) begin
            r_ent[i].vj <= w_wj[i][31:0];
            r_ent[i].rj <= 1'b1;
          end
          if (!r_ent[i].rk && w_wk[i][32]) begin
            r_ent[i].vk <= w_wk[i][31:0];
            r_ent[i].rk <= 1'b1;
          end
          if (w_fire && r_rank[i] > w_sel_rank) r_rank[i] <= r_rank[i] - 1'b1;
        end
      if (w_fire) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_fu              <= r_ent[w_sel_idx];
        r_fu_valid        <= 1'b1;
      end else if (r_fu_valid && bus.FU_ready) begin
        r_fu_valid <= 1'b0;
      end
      if (w_iss) begin
        r_busy[w_free_idx] <= 1'b1;
        r_ent[w_free_idx]  <= w_new;
        r_rank[w_free_idx] <= w_new_rank;
      end
    end
  end

  assign bus.FU_valid   = r_fu_valid;
  assign bus.FU_op      = r_fu.op;
  assign bus.FU_Vj      = r_fu.vj;
  assign bus.FU_Vk      = r_fu.vk;
  assign bus.FU_Imm     = r_fu.imm;
  assign bus.FU_DestRob = r_fu.dest;
  assign bus.FU_CurPC   = r_fu.pc;

  assign RS_count     = w_count;
  assign RS_next_full = (32'(w_count) + 32'd1) >= 32'(RS_SIZE);

endmodule

// File: tb/tb_rs_oldest_first.sv
// Directed bench for rs_oldest_first: ordering, bypass, backpressure, fill/flush, stall.
module tb_rs_oldest_first;
  localparam int RS_SIZE = 16;
  localparam int CNT_W   = $clog2(RS_SIZE) + 1;

  logic             clk = 1'b0;
  logic             rst, rdy, jump_flag;
  logic             RS_next_full;
  logic [CNT_W-1:0] RS_count;
  int               n_chk = 0;
  int               n_fail = 0;

  rs_oldest_first_if #(.ROB_LOG(4), .OP_LOG(6), .CDB_N(2)) bus();

  rs_oldest_first #(.RS_SIZE(RS_SIZE), .ROB_LOG(4), .OP_LOG(6), .CDB_N(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
    .RS_next_full(RS_next_full), .RS_count(RS_count), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue stimulus: Vj = pc+0x100 when ready, Vk = pc+0x200, Imm = ~pc
  task automatic iss(input logic v, input logic [31:0] pc, input logic rj, input logic [3:0] qj);
    bus.issue_valid   = v;
    bus.issue_op      = pc[7:2];
    bus.issue_Vj      = rj ? pc + 32'h100 : 32'h0;
    bus.issue_Vk      = pc + 32'h200;
    bus.issue_Rj      = rj;
    bus.issue_Rk      = 1'b1;
    bus.issue_Qj      = qj;
    bus.issue_Qk      = 4'd0;
    bus.issue_Imm     = ~pc;
    bus.issue_DestRob = pc[5:2];
    bus.issue_CurPC   = pc;
  endtask

  task automatic cdb(input logic [1:0] v, input logic [3:0] id0, input logic [31:0] val0,
                     input logic [3:0] id1, input logic [31:0] val1);
    bus.cdb_valid = v;
    bus.cdb_RobId = {id1, id0};
    bus.cdb_value = {val1, val0};
  endtask

  task automatic fu(input string tag, input logic v, input logic [31:0] pc, input logic [CNT_W-1:0] cnt);
    check({tag, ".valid"}, 32'(bus.FU_valid), 32'(v));
    if (v) check({tag, ".pc"}, bus.FU_CurPC, pc);
    check({tag, ".count"}, 32'(RS_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; bus.FU_ready = 1'b1;
    iss(1'b0, 32'h0, 1'b1, 4'd0);
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    step(); step();
    rst = 1'b0;
    check("rst.valid", 32'(bus.FU_valid), 32'd0);
    check("rst.count", 32'(RS_count), 32'd0);
    check("rst.nfull", 32'(RS_next_full), 32'd0);
    check("rst.pc",    bus.FU_CurPC, 32'd0);

    // back-to-back ready issues
    iss(1'b1, 32'h0, 1'b1, 4'd0); step(); fu("b2b1", 1'b0, 32'h0, 1);
    iss(1'b1, 32'h4, 1'b1, 4'd0); step(); fu("b2b2", 1'b1, 32'h0, 1);
    iss(1'b1, 32'h8, 1'b1, 4'd0); step(); fu("b2b3", 1'b1, 32'h4, 1);
    iss(1'b0, 32'h0, 1'b1, 4'd0); step(); fu("b2b4", 1'b1, 32'h8, 0);
    step(); fu("b2b5", 1'b0, 32'h0, 0);

    // age ordering: A waits on tag 3, B and C ready
    iss(1'b1, 32'h10, 1'b0, 4'd3); step(); fu("age1", 1'b0, 32'h0, 1);
    iss(1'b1, 32'h14, 1'b1, 4'd0); step(); fu("age2", 1'b0, 32'h0, 2);
    iss(1'b1, 32'h18, 1'b1, 4'd0); step(); fu("ageB", 1'b1, 32'h14, 2);
    iss(1'b0, 32'h0, 1'b1, 4'd0);
    cdb(2'b11, 4'd7, 32'h99, 4'd3, 32'h55); step(); fu("ageC", 1'b1, 32'h18, 1);
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); step(); fu("ageA", 1'b1, 32'h10, 0);
    check("ageA.vj",  bus.FU_Vj, 32'h55);
    check("ageA.vk",  bus.FU_Vk, 32'h210);
    check("ageA.imm", bus.FU_Imm, ~32'h10);
    check("ageA.op",  32'(bus.FU_op), 32'h04);
    check("ageA.dst", 32'(bus.FU_DestRob), 32'h4);
    step(); fu("age.drain", 1'b0, 32'h0, 0);

    // issue-cycle bypass, both channels match, channel 0 wins
    iss(1'b1, 32'h20, 1'b0, 4'd5);
    cdb(2'b11, 4'd5, 32'hDEAD, 4'd5, 32'hBEEF); step(); fu("byp1", 1'b0, 32'h0, 1);
    iss(1'b0, 32'h0, 1'b1, 4'd0);
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); step(); fu("byp2", 1'b1, 32'h20, 0);
    check("byp.vj", bus.FU_Vj, 32'hDEAD);
    step();

    // backpressure
    bus.FU_ready = 1'b0;
    iss(1'b1, 32'h40, 1'b1, 4'd0); step(); fu("bp1", 1'b0, 32'h0, 1);
    iss(1'b1, 32'h44, 1'b1, 4'd0); step(); fu("bp2", 1'b1, 32'h40, 1);
    iss(1'b0, 32'h0, 1'b1, 4'd0);
    for (int k = 0; k < 4; k++) begin
      step(); fu("bp.hold", 1'b1, 32'h40, 1);
      check("bp.vj", bus.FU_Vj, 32'h140);
    end
    bus.FU_ready = 1'b1; step(); fu("bp.rel", 1'b1, 32'h44, 0);
    step(); fu("bp.drain", 1'b0, 32'h0, 0);

    // fill: one ready op parks in the FU, then RS_SIZE waiting entries
    bus.FU_ready = 1'b0;
    iss(1'b1, 32'h60, 1'b1, 4'd0); step();
    for (int k = 1; k <= RS_SIZE; k++) begin
      iss(1'b1, 32'h100 + 32'(k * 4), 1'b0, 4'd9); step();
      if (k >= RS_SIZE - 2) begin
        check("fill.count", 32'(RS_count), 32'(k));
        check("fill.nfull", 32'(RS_next_full), 32'(k >= RS_SIZE - 1));
      end
    end
    check("fill.fuv", 32'(bus.FU_valid), 32'd1);
    iss(1'b1, 32'h200, 1'b1, 4'd0); step();
    check("fill.drop", 32'(RS_count), 32'(RS_SIZE));
    jump_flag = 1'b1; bus.FU_ready = 1'b1; step();
    fu("flush", 1'b0, 32'h0, 0);
    check("flush.nfull", 32'(RS_next_full), 32'd0);
    jump_flag = 1'b0; iss(1'b0, 32'h0, 1'b1, 4'd0); step();
    fu("flush.after", 1'b0, 32'h0, 0);

    // rdy stall mid-dispatch with a broadcast present
    bus.FU_ready = 1'b0;
    iss(1'b1, 32'h80, 1'b1, 4'd0); step();
    iss(1'b1, 32'h84, 1'b0, 4'd6); step(); fu("stall.pre", 1'b1, 32'h80, 1);
    rdy = 1'b0; bus.FU_ready = 1'b1;
    iss(1'b1, 32'h88, 1'b1, 4'd0);
    cdb(2'b01, 4'd6, 32'h66, 4'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(); fu("stall.hold", 1'b1, 32'h80, 1);
    end
    rdy = 1'b1; iss(1'b0, 32'h0, 1'b1, 4'd0);
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); step();
    fu("stall.res", 1'b0, 32'h0, 1);
    cdb(2'b10, 4'd0, 32'h0, 4'd6, 32'h77); step();
    fu("stall.wake", 1'b0, 32'h0, 1);
    cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); step();
    fu("stall.disp", 1'b1, 32'h84, 0);
    check("stall.vj", bus.FU_Vj, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
